exc_arbiter: RTL and testbench
==============================

EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the taken-exception counter.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port InvInstr  input  1  controller flags current instruction as undecodable, level, sampled each cycle.
REQ-005 SHALL have port ExtIRQ  input  1  external interrupt line, asynchronous, rising-edge significant.
REQ-006 SHALL have port ExcAck  input  1  datapath has taken the exception vector this cycle.
REQ-007 SHALL have port ERet  input  1  controller executing ERET, handler returning.
REQ-008 SHALL have port Exc  output  1  exception request to datapath/controller.
REQ-009 SHALL have port EStatus  output  4  cause code of the request being raised.
REQ-010 SHALL have port InHandler  output  1  high while an exception handler is executing.
REQ-011 SHALL have port ExcCount  output  CNT_W  number of exceptions taken, saturating.

Function
REQ-012 SHALL keep two sticky pending bits: PendInv (set when InvInstr=1), PendIrq (set on synchronized ExtIRQ rising edge).
REQ-013 SHALL pass ExtIRQ through a 2-flop synchronizer, then edge-detect; edge visible to pending logic 3 cycles after the input rises.
REQ-014 SHALL encode EStatus: 4'b0001 invalid instruction, 4'b0010 external IRQ, 4'b0000 none.
REQ-015 SHALL prioritize PendInv over PendIrq when both pending.
REQ-016 SHALL implement FSM IDLE, REQ, HANDLER.
REQ-017 IDLE: Exc=0, EStatus=0; if any pending bit set, next state REQ with EStatus latched from highest-priority pending source.
REQ-018 REQ: Exc=1, EStatus held constant; ExcAck=1 -> next state HANDLER, clear the served pending bit, ExcCount+1.
REQ-019 HANDLER: Exc=0, EStatus holds served cause, InHandler=1; new events still set pending bits but are not raised; ERet=1 -> next state IDLE.
REQ-020 ExcAck outside REQ and ERet outside HANDLER SHALL be ignored.
REQ-021 Same-cycle set and clear of one pending bit: set wins (bit stays 1).
REQ-022 Pending request left after ERet SHALL raise Exc exactly 2 cycles after the ERet cycle (one IDLE cycle).
REQ-023 A lower-priority source becoming pending during REQ SHALL NOT change EStatus until the next REQ entry.
REQ-024 ExcCount SHALL saturate at all-ones and never wrap.
REQ-025 Exc and EStatus SHALL be driven from registered state only, with no combinational path from inputs.

Reset
REQ-026 reset=1 at a rising edge SHALL force state IDLE, Exc=0, EStatus=0, InHandler=0, ExcCount=0, both pending bits=0, synchronizer flops=0.
REQ-027 reset SHALL override every other input, including mid-REQ and mid-HANDLER.
REQ-028 Events present during the reset cycle SHALL be discarded.

Structure
REQ-029 Package exc_pkg SHALL hold the FSM state enum and EStatus cause constants, shared with the controller.
REQ-030 Sub-module sync_edge (2-flop synchronizer + rising-edge detector, synchronous reset) SHALL be used for ExtIRQ.

Verification
REQ-031 InvInstr pulse 1 cycle in IDLE -> Exc=1, EStatus=0001 next cycle; ExcAck -> Exc=0, InHandler=1, ExcCount=1.
REQ-032 ExtIRQ rises at t -> Exc=1 with EStatus=0010 at t+4; Exc held through 5 cycles without ExcAck.
REQ-033 InvInstr and ExtIRQ edge pending together -> EStatus=0001 first; after ERet, Exc=1 with EStatus=0010 two cycles later.
REQ-034 ExtIRQ edge during HANDLER -> no Exc until ERet; spurious ERet in IDLE and ExcAck in HANDLER cause no state change.
REQ-035 reset asserted while in REQ -> next cycle Exc=0, EStatus=0, ExcCount=0, pending cleared, no later Exc without new event.
REQ-036 CNT_W=2, 5 exceptions taken -> ExcCount=3 after 3rd and stays 3.

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: shared FSM state encoding and EStatus cause codes for the exception arbiter
package exc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} exc_state_e;
  localparam logic [3:0] CAUSE_NONE = 4'b0000;
  localparam logic [3:0] CAUSE_INV  = 4'b0001;
  localparam logic [3:0] CAUSE_IRQ  = 4'b0010;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus registered rising-edge detector (d -> rise pulse 3 cycles later)
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/exc_arbiter.sv
// exc_arbiter: sticky-pending exception arbiter (invalid instr > external IRQ) with IDLE/REQ/HANDLER FSM and saturating taken counter
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InvInstr,
  input  logic             ExtIRQ,
  input  logic             ExcAck,
  input  logic             ERet,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic             InHandler,
  output logic [CNT_W-1:0] ExcCount
);
  exc_state_e state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic pend_inv_q, pend_irq_q, pend_inv_d, pend_irq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic irq_edge, eff_inv, eff_irq, clr_inv, clr_irq;
  sync_edge u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ExtIRQ),
    .rise (irq_edge)
  );
  // IDLE also looks at events arriving this cycle so a fresh InvInstr is raised on the next cycle
  assign eff_inv = pend_inv_q | InvInstr;
  assign eff_irq = pend_irq_q | irq_edge;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    clr_inv = 1'b0;
    clr_irq = 1'b0;
    case (state_q)
      IDLE: if (eff_inv | eff_irq) begin
        state_d = REQ;
        cause_d = eff_inv ? CAUSE_INV : CAUSE_IRQ;
      end
      REQ: if (ExcAck) begin
        state_d = HANDLER;
        clr_inv = cause_q == CAUSE_INV;
        clr_irq = cause_q == CAUSE_IRQ;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      end
      HANDLER: if (ERet) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // new event wins over a same-cycle clear
    pend_inv_d = (pend_inv_q & ~clr_inv) | InvInstr;
    pend_irq_d = (pend_irq_q & ~clr_irq) | irq_edge;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cause_q    <= CAUSE_NONE;
      pend_inv_q <= 1'b0;
      pend_irq_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      pend_inv_q <= pend_inv_d;
      pend_irq_q <= pend_irq_d;
      cnt_q      <= cnt_d;
    end
  end
  assign Exc       = state_q == REQ;
  assign EStatus   = state_q == IDLE ? CAUSE_NONE : cause_q;
  assign InHandler = state_q == HANDLER;
  assign ExcCount  = cnt_q;
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: scoreboard bench for exc_arbiter (8-bit counter instance plus 2-bit saturating instance)
module tb_exc_arbiter;
  logic clk = 1'b0;
  logic reset, InvInstr, ExtIRQ, ExcAck, ERet;
  logic Exc, InHandler, sat_exc, sat_inh;
  logic [3:0] EStatus, sat_es;
  logic [7:0] ExcCount;
  logic [1:0] sat_cnt;
  int n_chk = 0;
  int n_bad = 0;
  typedef struct {
    string tag;
    logic exc;
    logic [3:0] es;
    logic inh;
    int cnt;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  exc_arbiter u_dut (
    .clk(clk), .reset(reset), .InvInstr(InvInstr), .ExtIRQ(ExtIRQ), .ExcAck(ExcAck), .ERet(ERet),
    .Exc(Exc), .EStatus(EStatus), .InHandler(InHandler), .ExcCount(ExcCount)
  );
  exc_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .InvInstr(InvInstr), .ExtIRQ(ExtIRQ), .ExcAck(ExcAck), .ERet(ERet),
    .Exc(sat_exc), .EStatus(sat_es), .InHandler(sat_inh), .ExcCount(sat_cnt)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  // in = {reset, InvInstr, ExtIRQ, ExcAck, ERet}; expectations are the outputs after this cycle's edge
  task automatic cyc(input string tag, input logic [4:0] in, input logic e_exc, input logic [3:0] e_es,
                     input logic e_inh, input int e_cnt);
    exp_t e;
    {reset, InvInstr, ExtIRQ, ExcAck, ERet} = in;
    sb.push_back('{tag, e_exc, e_es, e_inh, e_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".exc"}, int'(Exc), int'(e.exc));
    chk({e.tag, ".es"}, int'(EStatus), int'(e.es));
    chk({e.tag, ".inh"}, int'(InHandler), int'(e.inh));
    chk({e.tag, ".cnt"}, int'(ExcCount), e.cnt);
    chk({e.tag, ".sat"}, int'(sat_cnt), e.cnt > 3 ? 3 : e.cnt);
  endtask
  initial begin
    {reset, InvInstr, ExtIRQ, ExcAck, ERet} = 5'b10000;
    #1;
    cyc("rst",        5'b10000, 0, 4'd0, 0, 0);
    cyc("idle",       5'b00000, 0, 4'd0, 0, 0);
    cyc("eret_idle",  5'b00001, 0, 4'd0, 0, 0);
    cyc("ack_idle",   5'b00010, 0, 4'd0, 0, 0);
    cyc("inv_req",    5'b01000, 1, 4'd1, 0, 0);
    cyc("inv_hold",   5'b00000, 1, 4'd1, 0, 0);
    cyc("inv_ack",    5'b00010, 0, 4'd1, 1, 1);
    cyc("ack_hdl",    5'b00010, 0, 4'd1, 1, 1);
    for (int i = 0; i < 6; i++) cyc("irq_hdl", 5'b00100, 0, 4'd1, 1, 1);
    cyc("irq_drop",   5'b00000, 0, 4'd1, 1, 1);
    cyc("eret1",      5'b00001, 0, 4'd0, 0, 1);
    cyc("pend_irq",   5'b00000, 1, 4'd2, 0, 1);
    for (int i = 0; i < 4; i++) cyc("irq_hold", 5'b00000, 1, 4'd2, 0, 1);
    cyc("irq_ack",    5'b00010, 0, 4'd2, 1, 2);
    cyc("eret2",      5'b00001, 0, 4'd0, 0, 2);
    cyc("quiet",      5'b00000, 0, 4'd0, 0, 2);
    for (int i = 0; i < 3; i++) cyc("irq_sync", 5'b00100, 0, 4'd0, 0, 2);
    cyc("irq_t4",     5'b00100, 1, 4'd2, 0, 2);
    cyc("irq_t5",     5'b00000, 1, 4'd2, 0, 2);
    cyc("irq_ack2",   5'b00010, 0, 4'd2, 1, 3);
    cyc("eret3",      5'b00001, 0, 4'd0, 0, 3);
    for (int i = 0; i < 3; i++) cyc("both_sync", 5'b00100, 0, 4'd0, 0, 3);
    cyc("both_req",   5'b01100, 1, 4'd1, 0, 3);
    cyc("both_hold",  5'b00000, 1, 4'd1, 0, 3);
    cyc("both_ack",   5'b00010, 0, 4'd1, 1, 4);
    cyc("both_eret",  5'b00001, 0, 4'd0, 0, 4);
    cyc("both_irq",   5'b00000, 1, 4'd2, 0, 4);
    cyc("both_ack2",  5'b00010, 0, 4'd2, 1, 5);
    cyc("both_eret2", 5'b00001, 0, 4'd0, 0, 5);
    cyc("both_idle",  5'b00000, 0, 4'd0, 0, 5);
    cyc("lp_req",     5'b01000, 1, 4'd1, 0, 5);
    for (int i = 0; i < 3; i++) cyc("lp_irq", 5'b00100, 1, 4'd1, 0, 5);
    cyc("lp_edge",    5'b00000, 1, 4'd1, 0, 5);
    cyc("lp_ack",     5'b00010, 0, 4'd1, 1, 6);
    cyc("lp_eret",    5'b00001, 0, 4'd0, 0, 6);
    cyc("lp_next",    5'b00000, 1, 4'd2, 0, 6);
    cyc("lp_ack2",    5'b00010, 0, 4'd2, 1, 7);
    cyc("lp_eret2",   5'b00001, 0, 4'd0, 0, 7);
    cyc("sw_req",     5'b01000, 1, 4'd1, 0, 7);
    cyc("sw_setclr",  5'b01010, 0, 4'd1, 1, 8);
    cyc("sw_eret",    5'b00001, 0, 4'd0, 0, 8);
    cyc("sw_again",   5'b00000, 1, 4'd1, 0, 8);
    cyc("sw_ack",     5'b00010, 0, 4'd1, 1, 9);
    cyc("sw_eret2",   5'b00001, 0, 4'd0, 0, 9);
    cyc("sw_idle",    5'b00000, 0, 4'd0, 0, 9);
    cyc("rr_req",     5'b01000, 1, 4'd1, 0, 9);
    cyc("rr_reset",   5'b11100, 0, 4'd0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("rr_quiet", 5'b00000, 0, 4'd0, 0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
